// File: rtl/neg_acc_pkg.sv
// Shared types, width helpers and saturation for the bit-serial weight-plane accumulator.
package neg_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int in_w(input int m, input int pa);
    return $clog2(m) + pa;
  endfunction

  function automatic int acc_w(input int m, input int pa, input int pw);
    return in_w(m, pa) + pw;
  endfunction

  // Clamp a signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/neg_shift_acc_lane.sv
// One channel: sign-extend, shift by plane index, add or subtract into the accumulator.
// With NEG_ACC_SAT_EN the output is a saturated register updated alongside the accumulator.
module neg_shift_acc_lane
  import neg_acc_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int ACC_W = 16,
  parameter int OUT_W = 16,
  parameter int SH_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              sub,
  input  logic [SH_W-1:0]   shamt,
  input  logic [IN_W-1:0]   din,
  output logic [OUT_W-1:0]  dout
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_nxt;

  always_comb begin
    term    = ACC_W'($signed(din)) <<< shamt;
    acc_nxt = sub ? (acc - term) : (acc + term);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end

`ifdef NEG_ACC_SAT_EN
  // Saturate the next value so the clamped word is ready in the same cycle as acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dout <= '0;
    else if (clr) dout <= '0;
    else if (en)  dout <= OUT_W'(saturate(64'(acc_nxt), OUT_W));
  end
`else
  assign dout = acc;
`endif

endmodule

// File: rtl/neg_shift_acc.sv
// Multi-lane bit-serial weight-plane accumulator; result valid one cycle after the last plane beat,
// held until out_ready; in_ready only while accumulating. NEG_ACC_SAT_EN enables OUT_W saturation.
module neg_shift_acc
  import neg_acc_pkg::*;
#(
  parameter int M     = 16,
  parameter int Pa    = 8,
  parameter int Pw    = 8,
  parameter int N     = 4,
  parameter int OUT_W = $clog2(M) + Pa + Pw,
  localparam int IN_W  = in_w(M, Pa),
  localparam int ACC_W = acc_w(M, Pa, Pw),
  localparam int BW    = $clog2(Pw) + 1,
`ifdef NEG_ACC_SAT_EN
  localparam int OW    = OUT_W
`else
  // Without saturation the full accumulator is always exposed.
  localparam int OW    = (OUT_W == ACC_W) ? OUT_W : ACC_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cl_en,
  input  logic              start,
  input  logic              w_signed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*IN_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*OW-1:0]   out_data,
  output logic [BW-1:0]     bit_idx,
  output logic              busy
);

  localparam logic [BW-1:0] LAST = BW'(Pw - 1);

  state_t state;
  logic   wsq;
  logic   last;
  logic   beat;
  logic   hs;
  logic   go;
  logic   clr;

  assign last = (bit_idx == LAST);
  assign beat = (state == ACCUM) && in_valid && !cl_en;
  assign hs   = (state == DONE) && out_ready;
  assign go   = !cl_en && start && ((state == IDLE) || hs);
  assign clr  = cl_en || go;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wsq     <= 1'b0;
      bit_idx <= '0;
    end else if (cl_en) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else if (go) begin
      state   <= ACCUM;
      wsq     <= w_signed;
      bit_idx <= '0;
    end else begin
      case (state)
        ACCUM: if (in_valid) begin
          bit_idx <= bit_idx + BW'(1);
          if (last) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_lane
    neg_shift_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .OUT_W (OW),
      .SH_W  (BW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (beat),
      .sub   (wsq && last),
      .shamt (bit_idx),
      .din   (in_data[c*IN_W +: IN_W]),
      .dout  (out_data[c*OW +: OW])
    );
  end

endmodule

// File: tb/tb_neg_shift_acc.sv
// Randomized bench for neg_shift_acc against a plane-sum reference model (M=16, Pa=8, Pw=4, N=2).
`timescale 1ns/1ps
module tb_neg_shift_acc;

  localparam int M     = 16;
  localparam int PA    = 8;
  localparam int PW    = 4;
  localparam int N     = 2;
  localparam int IN_W  = 12;
  localparam int ACC_W = 16;
  localparam int BW    = 3;
`ifdef NEG_ACC_SAT_EN
  localparam int OW    = 12;
`else
  localparam int OW    = ACC_W;
`endif

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cl_en = 1'b0;
  logic start = 1'b0;
  logic w_signed = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [N*IN_W-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic busy;
  logic [N*OW-1:0] out_data;
  logic [BW-1:0] bit_idx;

  neg_shift_acc #(.M(M), .Pa(PA), .Pw(PW), .N(N), .OUT_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .cl_en     (cl_en),
    .start     (start),
    .w_signed  (w_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bit_idx   (bit_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  int     exp_phase = P_IDLE;
  int     exp_k = 0;
  bit     cur_s = 1'b0;
  longint exp_res [N];
  int     vals [PW][N];

  task automatic chkv(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint lane_out(input int c);
    return longint'($signed(out_data[c*OW +: OW]));
  endfunction

  // Reference: sum of sign-extended plane values weighted by 2^k, MSB plane negated in signed mode.
  function automatic longint model(input bit s, input int c);
    longint acc;
    longint t;
    acc = 0;
    for (int k = 0; k < PW; k++) begin
      t = longint'(vals[k][c]) * (longint'(1) << k);
      if (s && k == PW - 1) acc -= t;
      else                  acc += t;
    end
`ifdef NEG_ACC_SAT_EN
    if (acc > (longint'(1) << (OW - 1)) - 1) acc = (longint'(1) << (OW - 1)) - 1;
    if (acc < -(longint'(1) << (OW - 1)))    acc = -(longint'(1) << (OW - 1));
`endif
    return acc;
  endfunction

  always @(negedge clk) begin
    chkv("in_ready", 64'(in_ready), 64'(exp_phase == P_ACC));
    chkv("busy", 64'(busy), 64'(exp_phase != P_IDLE));
    chkv("out_valid", 64'(out_valid), 64'(exp_phase == P_DONE));
    if (exp_phase == P_ACC) chkv("bit_idx", 64'(bit_idx), 64'(exp_k));
    if (exp_phase == P_DONE && out_valid)
      for (int c = 0; c < N; c++) chkv("out_data", lane_out(c), exp_res[c]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int k);
    for (int c = 0; c < N; c++) in_data[c*IN_W +: IN_W] = IN_W'(vals[k][c]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = (N*IN_W)'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_run(input bit s, input bit via_hs);
    start     = 1'b1;
    w_signed  = s;
    out_ready = via_hs;
    in_valid  = 1'($urandom_range(0, 1));
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    w_signed  = 1'($urandom_range(0, 1));
    cur_s     = s;
    exp_phase = P_ACC;
    exp_k     = 0;
  endtask

  task automatic beats(input int gap_max, input int nb);
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = (N*IN_W)'($urandom);
        start    = 1'($urandom_range(0, 1));
        tick();
      end
      start    = 1'b0;
      in_valid = 1'b1;
      set_lanes(k);
      tick();
      in_valid = 1'b0;
      exp_k    = k + 1;
      if (k == PW - 1) begin
        for (int c = 0; c < N; c++) exp_res[c] = model(cur_s, c);
        exp_phase = P_DONE;
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_phase = P_IDLE;
  endtask

  task automatic load_tp1();
    for (int k = 0; k < PW; k++) begin
      vals[k][0] = 5;
      vals[k][1] = (k == 0 || k == 3) ? 1 : 0;
    end
  endtask

  function automatic int rnd_val();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    bit chained;
    #2 rst = 1'b1;
    #1;
    chkv("rst_bit_idx", 64'(bit_idx), 64'(0));
    chkv("rst_lane0", lane_out(0), 64'(0));
    chkv("rst_busy", 64'(busy), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    idle(2);

    // Signed: 5 on every plane -> -5; 1,0,0,1 -> -7.
    load_tp1();
    start_run(1'b1, 1'b0);
    beats(0, PW);
    chkv("tp1_lane0", lane_out(0), -64'sd5);
    chkv("tp1_lane1", lane_out(1), -64'sd7);
    release_res();
    idle(1);

    // Unsigned: 75 and 9.
    start_run(1'b0, 1'b0);
    beats(0, PW);
    chkv("tp2_lane0", lane_out(0), 64'sd75);
    chkv("tp2_lane1", lane_out(1), 64'sd9);
    release_res();

    // Most-negative input in signed mode flips to +2048 (clamped in the saturating build).
    for (int k = 0; k < PW; k++) vals[k][0] = -2048;
    vals[0][1] = 3; vals[1][1] = -1; vals[2][1] = 7; vals[3][1] = -8;
    start_run(1'b1, 1'b0);
    beats(0, PW);
`ifdef NEG_ACC_SAT_EN
    chkv("tp3_lane0", lane_out(0), 64'sd2047);
`else
    chkv("tp3_lane0", lane_out(0), 64'sd2048);
`endif
    chkv("tp3_lane1", lane_out(1), 64'sd93);

    // Stall in DONE, then handshake together with start; next run has gaps.
    hold(5);
    start_run(1'b0, 1'b1);
    load_tp1();
    beats(3, PW);
    chkv("gap_lane0", lane_out(0), 64'sd75);
    chkv("gap_lane1", lane_out(1), 64'sd9);
    release_res();

    // Clear after two beats, asserted alongside start and in_valid.
    start_run(1'b1, 1'b0);
    beats(1, 2);
    cl_en = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    cl_en = 1'b0; start = 1'b0; in_valid = 1'b0;
    exp_phase = P_IDLE;
    chkv("clr_bit_idx", 64'(bit_idx), 64'(0));
    chkv("clr_lane0", lane_out(0), 64'(0));
    idle(2);

    // Clear in DONE overrides a same-cycle handshake and start.
    start_run(1'b1, 1'b0);
    beats(0, PW);
    cl_en = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    cl_en = 1'b0; out_ready = 1'b0; start = 1'b0;
    exp_phase = P_IDLE;
    chkv("clr_done_lane1", lane_out(1), 64'(0));
    idle(2);

    // Asynchronous reset in the middle of a run.
    start_run(1'b0, 1'b0);
    beats(0, 2);
    in_valid = 1'b1;
    set_lanes(2);
    #2 rst = 1'b1;
    #1;
    exp_phase = P_IDLE;
    chkv("arst_in_ready", 64'(in_ready), 64'(0));
    chkv("arst_busy", 64'(busy), 64'(0));
    chkv("arst_bit_idx", 64'(bit_idx), 64'(0));
    chkv("arst_lane0", lane_out(0), 64'(0));
    chkv("arst_lane1", lane_out(1), 64'(0));
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    idle(1);
    load_tp1();
    start_run(1'b1, 1'b0);
    beats(1, PW);
    chkv("post_rst_lane0", lane_out(0), -64'sd5);
    chkv("post_rst_lane1", lane_out(1), -64'sd7);
    release_res();

    // Randomized runs with gaps, stalls and back-to-back starts.
    chained = 1'b0;
    s = 1'($urandom_range(0, 1));
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < PW; k++)
        for (int c = 0; c < N; c++) vals[k][c] = rnd_val();
      if (!chained) begin
        idle($urandom_range(0, 2));
        start_run(s, 1'b0);
      end
      beats(3, PW);
      hold($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      chained = (r < 39) && ($urandom_range(0, 1) == 1);
      if (chained) start_run(s, 1'b1);
      else         release_res();
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
